// File: rtl/sync_timing_decoder_pkg.sv
// Shared types and default sizing for the sync timing decoder.
package sync_timing_decoder_pkg;

  localparam int CNT_W_DEF      = 10;
  localparam int LOCK_LINES_DEF = 2;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    MEASURE = 2'd1,
    VERIFY  = 2'd2,
    LOCK    = 2'd3
  } state_e;

endpackage

// File: rtl/sync_timing_decoder_edge_det.sv
// Single-stage input register with a rising-edge pulse (input high, registered copy low).
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic sig_q_o,
  output logic rise_o
);

  logic sig_q;

  // Input sample register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign sig_q_o = sig_q;
  assign rise_o  = sig_i & ~sig_q;

endmodule

// File: rtl/sync_timing_decoder.sv
// Measures the csync line period, locks after repeated equal lines and flywheels
// over a single missing pulse; produces line/frame position counters.
module sync_timing_decoder
  import sync_timing_decoder_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int LOCK_LINES = LOCK_LINES_DEF
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             csync,
  input  logic             vsync,
  input  logic             cblank,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] line_count,
  output logic [CNT_W-1:0] line_len,
  output logic             locked,
  output logic             line_start,
  output logic             frame_start,
  output logic             active,
  output logic             err
);

  localparam int MW = $clog2(LOCK_LINES + 1);
  // The match counter excludes the reference line, so lock needs LOCK_LINES-1 matches.
  localparam logic [MW-1:0] LOCK_MATCH = MW'(LOCK_LINES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] h_q, h_d, len_q, len_d, lc_q, lc_d;
  logic [MW-1:0]    match_q, match_d;
  logic             fly_q, fly_d;
  logic             ls_d, fly_tick, err_d;
  logic             locked_q, ls_q, fs_q, active_q, err_q;
  logic             csync_edge, vsync_edge, csync_lvl, vsync_lvl, cblank_lvl, cblank_edge;
  logic [CNT_W-1:0] hp1;
  logic             len_ok, h_max, h_wrap, lock_ready;
  logic             unused_s;

  sync_edge_det u_csync  (.clk_i(CK), .rst_i(RST), .sig_i(csync),  .sig_q_o(csync_lvl),  .rise_o(csync_edge));
  sync_edge_det u_vsync  (.clk_i(CK), .rst_i(RST), .sig_i(vsync),  .sig_q_o(vsync_lvl),  .rise_o(vsync_edge));
  sync_edge_det u_cblank (.clk_i(CK), .rst_i(RST), .sig_i(cblank), .sig_q_o(cblank_lvl), .rise_o(cblank_edge));

  assign unused_s   = ^{csync_lvl, vsync_lvl, cblank_edge};
  assign hp1        = h_q + CNT_W'(1);
  assign len_ok     = (hp1 == len_q);
  assign h_max      = &h_q;
  assign h_wrap     = (h_q == len_q - CNT_W'(1));
  assign lock_ready = ((match_q + MW'(1)) >= LOCK_MATCH);

  // State register and all registered outputs
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q  <= HUNT;
      h_q      <= {CNT_W{1'b0}};
      len_q    <= {CNT_W{1'b0}};
      lc_q     <= {CNT_W{1'b0}};
      match_q  <= {MW{1'b0}};
      fly_q    <= 1'b0;
      locked_q <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      len_q    <= len_d;
      lc_q     <= lc_d;
      match_q  <= match_d;
      fly_q    <= fly_d;
      locked_q <= (state_d == LOCK);
      ls_q     <= ls_d;
      fs_q     <= vsync_edge;
      active_q <= (state_d == LOCK) & ~cblank_lvl;
      err_q    <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT: begin
        if (csync_edge) state_d = MEASURE;
        else            state_d = HUNT;
      end
      MEASURE: begin
        if (csync_edge) state_d = VERIFY;
        else if (h_max) state_d = HUNT;
        else            state_d = MEASURE;
      end
      VERIFY: begin
        if (csync_edge) state_d = (len_ok && lock_ready) ? LOCK : VERIFY;
        else if (h_max) state_d = HUNT;
        else            state_d = VERIFY;
      end
      LOCK: begin
        if (csync_edge)          state_d = len_ok ? LOCK : HUNT;
        else if (h_wrap && fly_q) state_d = HUNT;
        else                     state_d = LOCK;
      end
      default: state_d = HUNT;
    endcase
  end

  // Datapath and pulse generation
  always_comb begin
    h_d      = hp1;
    len_d    = len_q;
    match_d  = match_q;
    fly_d    = 1'b0;
    ls_d     = 1'b0;
    fly_tick = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      HUNT: begin
        h_d  = {CNT_W{1'b0}};
        ls_d = csync_edge;
      end
      MEASURE: begin
        if (csync_edge) begin
          len_d   = hp1;
          h_d     = {CNT_W{1'b0}};
          match_d = {MW{1'b0}};
          ls_d    = 1'b1;
        end else if (h_max) begin
          h_d   = {CNT_W{1'b0}};
          err_d = 1'b1;
        end else begin
          h_d = hp1;
        end
      end
      VERIFY: begin
        if (csync_edge) begin
          h_d  = {CNT_W{1'b0}};
          ls_d = 1'b1;
          if (len_ok) begin
            match_d = match_q + MW'(1);
          end else begin
            len_d   = hp1;
            match_d = {MW{1'b0}};
          end
        end else if (h_max) begin
          h_d   = {CNT_W{1'b0}};
          err_d = 1'b1;
        end else begin
          h_d = hp1;
        end
      end
      LOCK: begin
        if (csync_edge) begin
          h_d   = {CNT_W{1'b0}};
          ls_d  = len_ok;
          err_d = ~len_ok;
        end else if (h_wrap) begin
          // Flywheel: a second consecutive missing pulse means the lock is lost.
          h_d      = {CNT_W{1'b0}};
          fly_tick = ~fly_q;
          fly_d    = ~fly_q;
          err_d    = fly_q;
        end else begin
          fly_d = fly_q;
        end
      end
      default: h_d = {CNT_W{1'b0}};
    endcase
    if (vsync_edge)             lc_d = {CNT_W{1'b0}};
    else if (ls_d || fly_tick) lc_d = lc_q + CNT_W'(1);
    else                       lc_d = lc_q;
  end

  assign h_count     = h_q;
  assign line_count  = lc_q;
  assign line_len    = len_q;
  assign locked      = locked_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign active      = active_q;
  assign err         = err_q;

endmodule

// File: doc/sync_timing_decoder.md
SYNC_TIMING_DECODER -- requirements
Module: sync_timing_decoder

Interface
REQ-001 Parameter: CNT_W, default 10, width of all position and length counters.
REQ-002 Parameter: LOCK_LINES, default 2, number of consecutive equal-length lines required before lock.
REQ-003 Port: CK  input  1  the only clock; all flops rise-edge on CK.
REQ-004 Port: RST  input  1  reset, synchronous, active-high.
REQ-005 Port: csync  input  1  composite sync, active-high; a rising edge marks a line start.
REQ-006 Port: vsync  input  1  vertical sync, active-high; a rising edge marks a frame start.
REQ-007 Port: cblank  input  1  blanking, active-high.
REQ-008 Port: h_count  output  CNT_W  cycles since the last accepted line start.
REQ-009 Port: line_count  output  CNT_W  lines since the last frame start.
REQ-010 Port: line_len  output  CNT_W  measured line period in cycles.
REQ-011 Port: locked  output  1  high only in state LOCK.
REQ-012 Port: line_start  output  1  one-cycle pulse per accepted csync rising edge.
REQ-013 Port: frame_start  output  1  one-cycle pulse per vsync rising edge.
REQ-014 Port: active  output  1  locked AND NOT registered cblank.
REQ-015 Port: err  output  1  one-cycle pulse on loss of lock or measurement timeout.

Function
REQ-016 csync, vsync and cblank SHALL each be registered once; edges SHALL be the current input high AND the registered copy low.
REQ-017 All outputs SHALL be registered; line_start and frame_start SHALL assert in the cycle after the edge is detected.
REQ-018 FSM states SHALL be HUNT, MEASURE, VERIFY, LOCK.
REQ-019 HUNT: on csync edge, clear h_count to 0 and go to MEASURE; otherwise h_count holds 0.
REQ-020 MEASURE: h_count increments each cycle; on csync edge, load line_len with h_count+1, clear h_count, clear the match counter, and go to VERIFY.
REQ-021 VERIFY: on csync edge, if h_count+1 equals line_len, increment the match counter; reaching LOCK_LINES goes to LOCK; otherwise reload line_len with h_count+1 and clear the match counter.
REQ-022 LOCK: a csync edge with h_count+1 not equal to line_len SHALL pulse err and go to HUNT.
REQ-023 LOCK: h_count reaching line_len-1 with no csync edge SHALL wrap h_count to 0 (flywheel) without pulsing line_start.
REQ-024 LOCK: a second consecutive flywheeled line SHALL pulse err and go to HUNT.
REQ-025 In MEASURE or VERIFY, h_count reaching all-ones with no csync edge SHALL pulse err and go to HUNT.
REQ-026 line_count SHALL increment on each line start (accepted or flywheeled) and SHALL wrap at all-ones.
REQ-027 A vsync edge SHALL clear line_count to 0 in any state; it takes priority over a same-cycle line-start increment.
REQ-028 A csync edge coincident with a flywheel wrap SHALL be treated as a single accepted line start.
REQ-029 line_start and frame_start SHALL pulse in all states; err SHALL pulse at most once per lock loss.

Reset
REQ-030 RST high SHALL, at the next CK edge, set state to HUNT and clear all counters, all input registers and all outputs to 0; this applies mid-line or mid-lock.
REQ-031 The first csync edge detected after RST deasserts SHALL be handled as in HUNT.

Structure
REQ-032 A shared package SHALL hold the FSM state enum and the CNT_W and LOCK_LINES defaults.
REQ-033 One sub-module, sync_edge_det (register plus rising-edge pulse), SHALL be instantiated three times.

Verification
REQ-034 Reset, then csync pulses every 64 cycles -> line_len=64; locked rises after the third edge; line_start pulses each line.
REQ-035 Locked at 64, then one csync edge at period 60 -> err pulses once, locked=0, state HUNT, relock after three good periods.
REQ-036 Locked at 64, drop one csync pulse -> h_count wraps at 63, no err, locked stays 1; drop two consecutive pulses -> err, locked=0.
REQ-037 vsync edge coincident with a line start after line 5 -> frame_start pulses, line_count=0 (not 1).
REQ-038 No csync for 1024 cycles after the first edge -> err pulses once, return to HUNT, h_count=0.
REQ-039 RST asserted for 1 cycle while locked -> all outputs 0 next cycle, then relock with the same 64-cycle stimulus.
